// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-stage control decode.
// One fetch_op_e value is resolved per edge from the redirect/stall inputs.
package mips_pkg;

  localparam int PCL_W = 32;
  localparam int IN_W  = 32;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    OP_ADVANCE  = 2'd0,
    OP_STALL    = 2'd1,
    OP_REDIRECT = 2'd2
  } fetch_op_e;

  // Redirect wins over stall: a resolved branch must not be held off by a decode hazard.
  function automatic fetch_op_e fetch_op(input logic redirect, input logic stall);
    if (redirect) begin
      return OP_REDIRECT;
    end
    if (stall) begin
      return OP_STALL;
    end
    return OP_ADVANCE;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with wrap-at-IMEM_DEPTH increment and redirect/stall select.
// pc_o is the register itself; pc_next_o is combinational from it. Stall holds the PC.
module pc_unit
  import mips_pkg::*;
#(
  parameter int             PCL        = PCL_W,
  parameter int             IMEM_DEPTH = 64,
  parameter logic [PCL-1:0] RESET_PC   = PCL'(RESET_PC_DEF)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall_i,
  input  logic           redirect_i,
  input  logic [PCL-1:0] target_i,
  output logic [PCL-1:0] pc_o,
  output logic [PCL-1:0] pc_next_o
);

  localparam logic [PCL-1:0] LAST_PC = PCL'(IMEM_DEPTH - 1);
  localparam logic [PCL-1:0] DEPTH   = PCL'(IMEM_DEPTH);

  logic [PCL-1:0] pc_q;
  logic [PCL-1:0] pc_d;
  logic [PCL-1:0] target_wrap;

  // IMEM_DEPTH is a power of two, so this reduces to keeping the low address bits.
  assign target_wrap = target_i % DEPTH;

  assign pc_next_o = (pc_q == LAST_PC) ? '0 : pc_q + PCL'(1);

  always_comb begin
    pc_d = pc_q;
    case (fetch_op(redirect_i, stall_i))
      OP_REDIRECT: pc_d = target_wrap;
      OP_STALL:    pc_d = pc_q;
      default:     pc_d = pc_next_o;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC drives imem, returned word + PC+1 captured into IF/ID one edge later.
// Stall holds PC and IF/ID; redirect reloads PC and inserts one bubble. FETCH_PERF_EN adds counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int             PCL        = PCL_W,
  parameter int             IN         = IN_W,
  parameter int             IMEM_DEPTH = 64,
  parameter logic [PCL-1:0] RESET_PC   = PCL'(RESET_PC_DEF)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [PCL-1:0] pc_o,
  input  logic [IN-1:0]  instr_i,
  input  logic           stall_i,
  input  logic           redirect_i,
  input  logic [PCL-1:0] target_i,
  output logic [IN-1:0]  ifid_instr_o,
  output logic [PCL-1:0] ifid_pcplus_o,
  output logic           ifid_valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]    fetch_cnt_o,
  output logic [31:0]    bubble_cnt_o
`endif
);

  localparam logic [IN-1:0] NOP = IN'(NOP_INSTR);

  fetch_op_e      op;
  logic [PCL-1:0] pc_next;

  assign op = fetch_op(redirect_i, stall_i);

  pc_unit #(
    .PCL        (PCL),
    .IMEM_DEPTH (IMEM_DEPTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_unit (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .redirect_i (redirect_i),
    .target_i   (target_i),
    .pc_o       (pc_o),
    .pc_next_o  (pc_next)
  );

  // IF/ID register; the wrong-path word fetched alongside a redirect is discarded as a NOP bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_o  <= NOP;
      ifid_pcplus_o <= '0;
      ifid_valid_o  <= 1'b0;
    end else begin
      case (op)
        OP_REDIRECT: begin
          ifid_instr_o  <= NOP;
          ifid_pcplus_o <= '0;
          ifid_valid_o  <= 1'b0;
        end
        OP_STALL: begin
          ifid_instr_o  <= ifid_instr_o;
          ifid_pcplus_o <= ifid_pcplus_o;
          ifid_valid_o  <= ifid_valid_o;
        end
        default: begin
          ifid_instr_o  <= instr_i;
          ifid_pcplus_o <= pc_next;
          ifid_valid_o  <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      case (op)
        OP_REDIRECT: bubble_cnt_o <= bubble_cnt_o + 32'd1;
        OP_ADVANCE:  fetch_cnt_o  <= fetch_cnt_o + 32'd1;
        default: begin
          fetch_cnt_o  <= fetch_cnt_o;
          bubble_cnt_o <= bubble_cnt_o;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a reference model of the fetch rules,
// with directed sequences pinning reset, stall, redirect-over-stall, wrap and async reset.
module tb_fetch_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pcplus_o;
  logic        ifid_valid_o;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;
`endif

  logic [31:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint unsigned m_pc;
  logic [31:0]     m_instr;
  logic [31:0]     m_pcplus;
  logic            m_valid;
  logic [31:0]     m_fcnt;
  logic [31:0]     m_bcnt;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_o          (pc_o),
    .instr_i       (instr_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .target_i      (target_i),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pcplus_o (ifid_pcplus_o),
    .ifid_valid_o  (ifid_valid_o)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  assign instr_i = mem[pc_o[5:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what IF/ID and PC must hold after each edge, from the stage's rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc     = 0;
      m_instr  = 32'h0;
      m_pcplus = 32'h0;
      m_valid  = 1'b0;
      m_fcnt   = 32'h0;
      m_bcnt   = 32'h0;
    end else if (redirect_i) begin
      m_pc     = longint'(target_i) % DEPTH;
      m_instr  = 32'h0;
      m_pcplus = 32'h0;
      m_valid  = 1'b0;
      m_bcnt   = m_bcnt + 32'd1;
    end else if (!stall_i) begin
      m_instr  = mem[m_pc];
      m_pc     = (m_pc + 1) % DEPTH;
      m_pcplus = 32'(m_pc);
      m_valid  = 1'b1;
      m_fcnt   = m_fcnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    chk("pc", pc_o, 32'(m_pc));
    chk("ifid_instr", ifid_instr_o, m_instr);
    chk("ifid_pcplus", ifid_pcplus_o, m_pcplus);
    chk("ifid_valid", {31'b0, ifid_valid_o}, {31'b0, m_valid});
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt_o, m_fcnt);
    chk("bubble_cnt", bubble_cnt_o, m_bcnt);
`endif
  end

  // Drive inputs for the next edge, then return at the following negedge.
  task automatic cyc(input logic r, input logic s, input logic [31:0] t);
    redirect_i = r;
    stall_i    = s;
    target_i   = t;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'h2000_0000 + k;
    rst_n      = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    target_i   = 32'h0;
    @(negedge clk);

    // Reset held while control inputs toggle
    for (int i = 0; i < 4; i++) cyc(i[0], i[1], 32'd17);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_valid", {31'b0, ifid_valid_o}, 32'd0);
    chk("rst_instr", ifid_instr_o, 32'd0);
    rst_n = 1'b1;

    cyc(0, 0, 0);
    chk("first_instr", ifid_instr_o, 32'h2000_0000);
    chk("first_pcplus", ifid_pcplus_o, 32'd1);
    chk("first_pc", pc_o, 32'd1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Stall at pc=3 for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'd9);
      chk("stall_pc", pc_o, 32'd3);
      chk("stall_instr", ifid_instr_o, 32'h2000_0002);
      chk("stall_pcplus", ifid_pcplus_o, 32'd3);
    end
    cyc(0, 0, 0);
    chk("resume_instr", ifid_instr_o, 32'h2000_0003);
    chk("resume_pc", pc_o, 32'd4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("seq_pc7", pc_o, 32'd7);

    // Redirect beats stall
    cyc(1, 1, 32'd40);
    chk("redir_pc", pc_o, 32'd40);
    chk("redir_valid", {31'b0, ifid_valid_o}, 32'd0);
    cyc(0, 0, 0);
    chk("redir_instr", ifid_instr_o, 32'h2000_0028);
    chk("redir_pcplus", ifid_pcplus_o, 32'd41);

    // Run to the end of memory and wrap
    for (int i = 0; i < 22; i++) cyc(0, 0, 0);
    chk("pc63", pc_o, 32'd63);
    cyc(0, 0, 0);
    chk("wrap_pc", pc_o, 32'd0);
    chk("wrap_pcplus", ifid_pcplus_o, 32'd0);
    chk("wrap_instr", ifid_instr_o, 32'h2000_003F);
    cyc(1, 0, 32'd70);
    chk("tgt_mod_pc", pc_o, 32'd6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s;
      logic [31:0] t;
      r = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH - 1));
      cyc(r, s, t);
    end

    // Async reset between edges while a redirect is pending
    redirect_i = 1'b1;
    target_i   = 32'd12;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_valid", {31'b0, ifid_valid_o}, 32'd0);
    chk("arst_instr", ifid_instr_o, 32'd0);
    chk("arst_pcplus", ifid_pcplus_o, 32'd0);
`ifdef FETCH_PERF_EN
    chk("arst_fcnt", fetch_cnt_o, 32'd0);
    chk("arst_bcnt", bubble_cnt_o, 32'd0);
`endif
    @(negedge clk);
    cyc(1, 1, 32'd5);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    chk("post_rst_pc", pc_o, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
